alsu_cmd_issuer: RTL and testbench
==================================

// Module: alsu_cmd_issuer
// PURPOSE
//  Upstream command stage for the ALSU. Accepts packed 16-bit op commands over a valid/ready
//  handshake and buffers them in a small FIFO. Drives each command onto the ALSU inputs for a
//  fixed hold window, then captures the ALSU out/leds. Returns the result to the requester
//  over a second valid/ready handshake. Only one command is in flight in the ALSU at a time.
// PARAMETERS
//  DEPTH         4   command FIFO entries; power of 2, >=2
//  HOLD_CYCLES   4   cycles each command is held on ALSU inputs; must be >= ALSU_LATENCY+1
//  ALSU_LATENCY  2   ALSU input-to-out register latency (informational; checked at elaboration)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset (0 = reset)
//  cmd_valid    in   1   command word present
//  cmd_ready    out  1   FIFO can accept (registered, = !full)
//  cmd_data     in   16  [15]cin [14]serial_in [13]red_op_A [12]red_op_B [11]bypass_A
//                        [10]bypass_B [9]direction [8:6]opcode [5:3]A [2:0]B
//  rsp_valid    out  1   result held in rsp_data/rsp_err
//  rsp_ready    in   1   requester takes result
//  rsp_data     out  6   captured ALSU out
//  rsp_err      out  1   captured (leds != 0): ALSU flagged invalid op
//  fifo_level   out  $clog2(DEPTH)+1  entries currently buffered
//  alsu_A,alsu_B,alsu_opcode  out 3 each; alsu_cin,alsu_serial_in,alsu_red_op_A,alsu_red_op_B,
//  alsu_bypass_A,alsu_bypass_B,alsu_direction  out 1 each; drive ALSU inputs (registered)
//  alsu_out     in   6   ALSU out
//  alsu_leds    in   16  ALSU leds
// BEHAVIOUR
//  Reset (rst=0, async): FIFO emptied, fifo_level=0, cmd_ready=0, rsp_valid=0, rsp_data=0,
//   rsp_err=0, all alsu_* = 0, FSM=IDLE, hold counter=0. cmd_ready rises on 1st edge after release.
//   Reset mid-operation discards the in-flight command and any buffered commands.
//  Push: cmd_valid&&cmd_ready at an edge writes cmd_data; cmd_ready registered from next-state full.
//   A push while full is impossible (ready low); cmd_data is ignored when cmd_valid=0.
//  Pop and push in the same edge: both occur; level unchanged; ready stays high.
//  FSM:
//   IDLE  : if FIFO non-empty -> pop head, load alsu_* from it, counter=0 -> ISSUE.
//           If empty, stay; alsu_* hold last issued values (0 after reset).
//   ISSUE : alsu_* stable; counter++ each edge; at the edge where counter==HOLD_CYCLES-1,
//           capture rsp_data<=alsu_out, rsp_err<=|alsu_leds, rsp_valid<=1 -> RESP.
//   RESP  : hold rsp_* stable until rsp_valid&&rsp_ready at an edge, then rsp_valid<=0 -> IDLE.
//           No new command is issued while in RESP.
//  Timing: a command accepted at edge E0 into an empty FIFO in IDLE drives alsu_* after edge E1.
//   The result is captured at edge E1+HOLD_CYCLES, and rsp_valid is high after that edge.
//   The handshake at edge Er returns the FSM to IDLE; next alsu_* update at Er+1 earliest.
//  Pointers wrap modulo DEPTH; level counts 0..DEPTH inclusive.
//  Each command is returned exactly once, in FIFO order.
// TESTING
//  1 Reset: rst=0 for 3 cycles -> all outputs 0; release -> cmd_ready=1 after 1st edge, level=0.
//  2 Single op: push 16'h002B (opcode 000 AND, A=101, B=011) with rsp_ready=1 -> alsu_A=5,
//    alsu_B=3 one edge later; rsp_valid after 4 more edges, rsp_data=6'b000001, rsp_err=0.
//  3 Full: with rsp_ready=0, push 6 commands back-to-back -> 1 issued, 4 buffered,
//    cmd_ready=0 at level 4; 6th push stalls until the first rsp handshake.
//  4 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_data stable, alsu_* unchanged, no new
//    issue; raising rsp_ready -> next command drives alsu_* one edge after the handshake.
//  5 Invalid op: opcode 3'b110 (ALSU leds active) -> rsp_err=1; the result still returns in order.
//  6 Mid-op reset: assert rst=0 during ISSUE with 3 buffered -> all outputs 0 immediately,
//    level=0; after release no stale response ever appears.

Source files
------------

// File: rtl/alsu_cmd_issuer.sv
// Command stage in front of the ALSU: buffers packed op commands, holds each on the ALSU
// inputs for a fixed window, then captures out/leds and returns them over valid/ready.
module alsu_cmd_issuer #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned ALSU_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [15:0]             cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [5:0]              rsp_data,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [2:0]              alsu_A,
    output logic [2:0]              alsu_B,
    output logic [2:0]              alsu_opcode,
    output logic                    alsu_cin,
    output logic                    alsu_serial_in,
    output logic                    alsu_red_op_A,
    output logic                    alsu_red_op_B,
    output logic                    alsu_bypass_A,
    output logic                    alsu_bypass_B,
    output logic                    alsu_direction,
    input  logic [5:0]              alsu_out,
    input  logic [15:0]             alsu_leds
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // The hold window must outlast the ALSU pipeline or a stale result is captured.
    if (HOLD_CYCLES < ALSU_LATENCY + 1) begin : g_bad_hold
        $error("alsu_cmd_issuer: HOLD_CYCLES must be >= ALSU_LATENCY+1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alsu_cmd_issuer: DEPTH must be a power of 2 and >= 2");
    end

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              pop;
    logic              push;
    logic              capture;
    logic              rsp_done;
    logic [LVL_W-1:0]  level_next;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [15:0]       mem [DEPTH];
    logic [15:0]       issue_cmd;

    assign push       = cmd_valid && cmd_ready;
    assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

    // State and hold-counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and per-edge control decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FIFO pointers, level and registered ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cmd_ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= level_next;
            cmd_ready  <= (level_next != LVL_W'(DEPTH));
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_data;
    end

    // Issued command and captured response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cmd <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) issue_cmd <= mem[rd_ptr];
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alsu_out;
                rsp_err   <= |alsu_leds;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign alsu_cin       = issue_cmd[15];
    assign alsu_serial_in = issue_cmd[14];
    assign alsu_red_op_A  = issue_cmd[13];
    assign alsu_red_op_B  = issue_cmd[12];
    assign alsu_bypass_A  = issue_cmd[11];
    assign alsu_bypass_B  = issue_cmd[10];
    assign alsu_direction = issue_cmd[9];
    assign alsu_opcode    = issue_cmd[8:6];
    assign alsu_A         = issue_cmd[5:3];
    assign alsu_B         = issue_cmd[2:0];

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Directed bench for alsu_cmd_issuer with a small two-stage ALSU stand-in driving out/leds.
module tb_alsu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_data;
    logic        rsp_err;
    logic [2:0]  fifo_level;
    logic [2:0]  alsu_A, alsu_B, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
    logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
    logic [5:0]  alsu_out  = '0;
    logic [15:0] alsu_leds = '0;

    int vectors = 0;
    int errors  = 0;

    alsu_cmd_issuer #(.DEPTH(4), .HOLD_CYCLES(4), .ALSU_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fifo_level(fifo_level),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds)
    );

    always #5 clk = ~clk;

    // ALSU stand-in: AND/XOR/ADD, opcodes 110/111 invalid; two register stages.
    logic [5:0]  p1_out  = '0;
    logic [15:0] p1_leds = '0;
    always @(posedge clk) begin
        case (alsu_opcode)
            3'b000:  begin p1_out <= {3'b000, alsu_A & alsu_B}; p1_leds <= 16'h0000; end
            3'b001:  begin p1_out <= {3'b000, alsu_A ^ alsu_B}; p1_leds <= 16'h0000; end
            3'b010:  begin p1_out <= 6'(alsu_A) + 6'(alsu_B);   p1_leds <= 16'h0000; end
            3'b110, 3'b111: begin p1_out <= 6'd0; p1_leds <= 16'hFFFF; end
            default: begin p1_out <= 6'd0; p1_leds <= 16'h0000; end
        endcase
        alsu_out  <= p1_out;
        alsu_leds <= p1_leds;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        logic acc;
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        for (int i = 0; i < 50; i++) begin
            acc = cmd_ready;
            step();
            if (acc) begin ok = 1'b1; break; end
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            vectors++; errors++;
            $display("FAIL push_timeout data=%h never accepted", d);
        end
    endtask

    task automatic collect(input string name, input logic [5:0] exp_data, input logic exp_err);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL %s rsp_timeout got rsp_valid=0 expected 1", name);
        end else if ({rsp_data, rsp_err} !== {exp_data, exp_err}) begin
            errors++;
            $display("FAIL %s got data=%h err=%b expected data=%h err=%b",
                     name, rsp_data, rsp_err, exp_data, exp_err);
        end
    endtask

    task automatic test_reset();
        logic [17:0] alsu_all;
        rst = 1'b0; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        alsu_all = {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_red_op_A,
                    alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction,
                    2'b00};
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, fifo_level} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h re=%b lvl=%0d expected all 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_err, fifo_level);
        end
        vectors++;
        if (alsu_all !== 18'h0) begin
            errors++;
            $display("FAIL reset_alsu got %h expected 0", alsu_all);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({cmd_ready, fifo_level} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_release got rdy=%b lvl=%0d expected rdy=1 lvl=0", cmd_ready, fifo_level);
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 16'h002B;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd1) begin
            errors++; $display("FAIL single_level got %0d expected 1", fifo_level);
        end
        step();
        vectors++;
        if ({alsu_opcode, alsu_A, alsu_B, fifo_level} !== {3'd0, 3'd5, 3'd3, 3'd0}) begin
            errors++;
            $display("FAIL single_issue got op=%0d A=%0d B=%0d lvl=%0d expected op=0 A=5 B=3 lvl=0",
                     alsu_opcode, alsu_A, alsu_B, fifo_level);
        end
        repeat (3) step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_early got rsp_valid=%b expected 0", rsp_valid);
        end
        step();
        vectors++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 6'b000001, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp got rv=%b data=%h err=%b expected rv=1 data=01 err=0",
                     rsp_valid, rsp_data, rsp_err);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_done got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    // Six commands with rsp_ready low, then backpressure, invalid op and in-order drain.
    task automatic test_full_backpressure();
        logic [16:0] snap;
        rsp_ready = 1'b0;
        push(16'h002B);
        push(16'h0073);
        push(16'h00BF);
        push(16'h018A);
        push(16'h003E);
        vectors++;
        if ({fifo_level, cmd_ready, alsu_A, alsu_B} !== {3'd4, 1'b0, 3'd5, 3'd3}) begin
            errors++;
            $display("FAIL full_level got lvl=%0d rdy=%b A=%0d B=%0d expected lvl=4 rdy=0 A=5 B=3",
                     fifo_level, cmd_ready, alsu_A, alsu_B);
        end
        cmd_valid = 1'b1;
        cmd_data  = 16'h0057;
        step();
        vectors++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 6'd1, 1'b0}) begin
            errors++;
            $display("FAIL full_first_rsp got rv=%b data=%h err=%b expected rv=1 data=01 err=0",
                     rsp_valid, rsp_data, rsp_err);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            snap = {rsp_valid, rsp_data, alsu_A, alsu_B, fifo_level, cmd_ready};
            vectors++;
            if (snap !== {1'b1, 6'd1, 3'd5, 3'd3, 3'd4, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d got %h expected %h",
                         i, snap, {1'b1, 6'd1, 3'd5, 3'd3, 3'd4, 1'b0});
            end
        end
        rsp_ready = 1'b1;
        step();
        vectors++;
        if ({rsp_valid, alsu_A, fifo_level} !== {1'b0, 3'd5, 3'd4}) begin
            errors++;
            $display("FAIL handshake_edge got rv=%b A=%0d lvl=%0d expected rv=0 A=5 lvl=4",
                     rsp_valid, alsu_A, fifo_level);
        end
        step();
        vectors++;
        if ({alsu_opcode, alsu_A, alsu_B, fifo_level, cmd_ready} !== {3'd1, 3'd6, 3'd3, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL next_issue got op=%0d A=%0d B=%0d lvl=%0d rdy=%b expected op=1 A=6 B=3 lvl=3 rdy=1",
                     alsu_opcode, alsu_A, alsu_B, fifo_level, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        vectors++;
        if ({fifo_level, cmd_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL stalled_push got lvl=%0d rdy=%b expected lvl=4 rdy=0", fifo_level, cmd_ready);
        end
        collect("order_c1_xor", 6'd5,  1'b0);
        collect("order_c2_add", 6'd14, 1'b0);
        collect("invalid_op",   6'd0,  1'b1);
        collect("order_c4_and", 6'd6,  1'b0);
        collect("order_c5_xor", 6'd5,  1'b0);
        step();
        vectors++;
        if ({rsp_valid, fifo_level} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL drained got rv=%b lvl=%0d expected rv=0 lvl=0", rsp_valid, fifo_level);
        end
    endtask

    task automatic test_midop_reset();
        logic stale;
        rsp_ready = 1'b1;
        push(16'h002B);
        push(16'h0073);
        push(16'h00BF);
        push(16'h018A);
        vectors++;
        if (fifo_level !== 3'd3) begin
            errors++; $display("FAIL midop_level got %0d expected 3", fifo_level);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, fifo_level, alsu_A, alsu_B, alsu_opcode}
            !== 21'h0) begin
            errors++;
            $display("FAIL midop_reset got rdy=%b rv=%b lvl=%0d A=%0d B=%0d op=%0d expected all 0",
                     cmd_ready, rsp_valid, fifo_level, alsu_A, alsu_B, alsu_opcode);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid || (fifo_level != 3'd0)) stale = 1'b1;
        end
        vectors++;
        if ({stale, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL midop_stale got stale=%b rdy=%b expected stale=0 rdy=1", stale, cmd_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_full_backpressure();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
